pipe_hazard_ctrl: RTL and testbench

Central stall/bubble controller for the 5-stage pipelined datapath (IF, ID, EX, MEM, WB). It keeps a scoreboard of the destination-register addresses and write-enables in flight through EX, MEM and WB. It compares the ID-stage source addresses against that scoreboard and drives the load enables of the pipeline registers, including the 3-bit destination-address registers. The datapath has no forwarding, so this block resolves every RAW hazard by stalling.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/hazard_scoreboard.sv | 60 ++++++
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/bubble controller:
//   default widths, scoreboard slot indices, and the {v, rd} slot layout.
package pipe_ctrl_pkg;

    localparam int PC_ADDR_W = 3;   // register-file address width of the datapath
    localparam int PC_CNT_W  = 16;  // performance counter width

    // Scoreboard slot positions; slot 0 is the instruction currently in EX.
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    // One scoreboard entry at the datapath's native address width.
    // v already has the write-enable and zero-register test folded in.
    typedef struct packed {
        logic                 v;
        logic [PC_ADDR_W-1:0] rd;
    } slot_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   DEPTH-slot shift register of in-flight destination registers (EX, MEM,
//   WB, ...) and a per-slot match vector against one source address.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset (clears every slot)
//   i_shift          advance the pipe: slot[i+1] <= slot[i], slot0 <= insert
//   i_bubble         when shifting, insert an invalid slot instead of ID
//   i_ins_v          ID instruction is valid and writes the register file
//   i_ins_rd         ID destination address
//   i_rs             source address to compare
//   o_match[i]       slot i is live and its rd equals i_rs
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W   = PC_ADDR_W,
    parameter int DEPTH    = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_shift,
    input  logic              i_bubble,
    input  logic              i_ins_v,
    input  logic [ADDR_W-1:0] i_ins_rd,
    input  logic [ADDR_W-1:0] i_rs,
    output logic [DEPTH-1:0]  o_match
);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
    } sb_slot_t;

    sb_slot_t [DEPTH-1:0] r_slot;
    sb_slot_t             w_ins;

    // Only "live" is stored: a write to r0 never needs to be waited on.
    always_comb begin
        w_ins.v  = i_ins_v && !i_bubble && ((ZERO_REG == 0) || (i_ins_rd != '0));
        w_ins.rd = i_ins_rd;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot <= '0;
        end else if (i_shift) begin
            r_slot[SLOT_EX] <= w_ins;
            for (int i = 1; i < DEPTH; i++) begin
                r_slot[i] <= r_slot[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign o_match[gi] = r_slot[gi].v && (r_slot[gi].rd == i_rs);
        end
    endgenerate

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/bubble controller for a 5-stage pipe without forwarding. Every RAW
//   hazard between the ID sources and an in-flight destination is resolved
//   by holding PC and IF/ID while a bubble is fed into ID/EX.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_id_valid                     ID holds a real instruction
//   i_id_rs1/_used, i_id_rs2/_used ID source addresses and their use flags
//   i_id_rd, i_id_we               ID destination and register write enable
//   i_mem_wait                     data memory busy: freeze everything
//   i_flush                        taken branch in EX: kill IF/ID
//   o_pc_en, o_ifid_en, o_ifid_clr load enables / NOP-load for PC and IF/ID
//   o_idex_bubble                  ID/EX loads a NOP
//   o_pipe_en                      ID/EX, EX/MEM, MEM/WB load enable
//   o_hazard                       RAW hazard seen this cycle
//   o_stall_cnt, o_flush_cnt       saturating event counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W    = PC_ADDR_W,
    parameter int DEPTH     = 3,
    parameter int WB_BYPASS = 1,
    parameter int ZERO_REG  = 1,
    parameter int CNT_W     = PC_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_id_valid,
    input  logic [ADDR_W-1:0] i_id_rs1,
    input  logic              i_id_rs1_used,
    input  logic [ADDR_W-1:0] i_id_rs2,
    input  logic              i_id_rs2_used,
    input  logic [ADDR_W-1:0] i_id_rd,
    input  logic              i_id_we,
    input  logic              i_mem_wait,
    input  logic              i_flush,
    output logic              o_pc_en,
    output logic              o_ifid_en,
    output logic              o_ifid_clr,
    output logic              o_idex_bubble,
    output logic              o_pipe_en,
    output logic              o_hazard,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    // With a write-before-read register file the WB slot is already visible
    // to ID, so it drops out of the compare set.
    localparam int CMP_N = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    logic [DEPTH-1:0] w_cmp_mask;
    logic [DEPTH-1:0] w_m1;
    logic [DEPTH-1:0] w_m2;
    logic             w_ins_v;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_haz;
    logic             w_shift;
    logic             w_bubble;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
            assign w_cmp_mask[gi] = (gi < CMP_N);
        end
    endgenerate

    assign w_ins_v = i_id_valid && i_id_we;

    // One scoreboard per source port; both see identical shift/insert
    // controls so their contents stay identical.
    hazard_scoreboard #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_sb_rs1 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_shift  (w_shift),
        .i_bubble (w_bubble),
        .i_ins_v  (w_ins_v),
        .i_ins_rd (i_id_rd),
        .i_rs     (i_id_rs1),
        .o_match  (w_m1)
    );

    hazard_scoreboard #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_sb_rs2 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_shift  (w_shift),
        .i_bubble (w_bubble),
        .i_ins_v  (w_ins_v),
        .i_ins_rd (i_id_rd),
        .i_rs     (i_id_rs2),
        .o_match  (w_m2)
    );

    assign w_rs1_hit = i_id_rs1_used && ((ZERO_REG == 0) || (i_id_rs1 != '0))
                       && |(w_m1 & w_cmp_mask);
    assign w_rs2_hit = i_id_rs2_used && ((ZERO_REG == 0) || (i_id_rs2 != '0))
                       && |(w_m2 & w_cmp_mask);

    // A flushed ID instruction is dead, so it cannot be stalled on.
    assign w_haz    = i_id_valid && !i_flush && (w_rs1_hit || w_rs2_hit);
    assign o_hazard = i_rst_n && w_haz;

    // Priority: mem_wait > flush > hazard > normal. During reset and
    // mem_wait every enable stays low and the scoreboard holds.
    always_comb begin
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_ifid_clr    = 1'b0;
        o_idex_bubble = 1'b0;
        o_pipe_en     = 1'b0;
        w_shift       = 1'b0;
        w_bubble      = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        if (i_rst_n && !i_mem_wait) begin
            o_pipe_en = 1'b1;
            w_shift   = 1'b1;
            if (i_flush) begin
                o_pc_en       = 1'b1;
                o_ifid_en     = 1'b1;
                o_ifid_clr    = 1'b1;
                o_idex_bubble = 1'b1;
                w_bubble      = 1'b1;
                w_flush_inc   = 1'b1;
            end else if (w_haz) begin
                o_idex_bubble = 1'b1;
                w_bubble      = 1'b1;
                w_stall_inc   = 1'b1;
            end else begin
                o_pc_en   = 1'b1;
                o_ifid_en = 1'b1;
            end
        end
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances share the stimulus: u0 at the
// default parameters, u1 with WB_BYPASS=0 and a 3-bit counter so saturation
// is reachable. The reference model keeps, per instance, the list of
// destination registers written by the last three instructions that entered
// EX (-1 = nothing written) and decides stall/flush/proceed from the rules.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, rs1_used, rs2_used, we, mem_wait, flush;
    logic [2:0] rs1, rs2, rd;

    logic        p0, f0, c0, b0, e0, h0, p1, f1, c1, b1, e1, h1;
    logic [15:0] s0, fl0;
    logic [2:0]  s1, fl1;

    logic [5:0]  av[2];
    logic [15:0] as[2];
    logic [15:0] af[2];
    assign av[0] = {p0, f0, c0, b0, e0, h0};
    assign av[1] = {p1, f1, c1, b1, e1, h1};
    assign as[0] = s0;
    assign as[1] = {13'b0, s1};
    assign af[0] = fl0;
    assign af[1] = {13'b0, fl1};

    always #5 clk = ~clk;

    pipe_hazard_ctrl u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
        .i_id_rs1(rs1), .i_id_rs1_used(rs1_used), .i_id_rs2(rs2), .i_id_rs2_used(rs2_used),
        .i_id_rd(rd), .i_id_we(we), .i_mem_wait(mem_wait), .i_flush(flush),
        .o_pc_en(p0), .o_ifid_en(f0), .o_ifid_clr(c0), .o_idex_bubble(b0),
        .o_pipe_en(e0), .o_hazard(h0), .o_stall_cnt(s0), .o_flush_cnt(fl0)
    );

    pipe_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(3)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
        .i_id_rs1(rs1), .i_id_rs1_used(rs1_used), .i_id_rs2(rs2), .i_id_rs2_used(rs2_used),
        .i_id_rd(rd), .i_id_we(we), .i_mem_wait(mem_wait), .i_flush(flush),
        .o_pc_en(p1), .o_ifid_en(f1), .o_ifid_clr(c1), .o_idex_bubble(b1),
        .o_pipe_en(e1), .o_hazard(h1), .o_stall_cnt(s1), .o_flush_cnt(fl1)
    );

    // ---------------- reference model ----------------
    int         q[2][3];           // q[d][0] = newest instruction in EX
    int         sc[2], fc[2];
    int         smax[2] = '{65535, 7};
    int         dec[2];            // 0 hold, 1 flush, 2 stall, 3 proceed, 4 reset
    logic [5:0] ev[2];             // {pc, ifid, clr, bubble, pipe, hazard}
    int         total = 0;
    int         bad = 0;

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) q[d][k] = -1;
            sc[d] = 0;
            fc[d] = 0;
        end
    endtask

    function automatic bit in_recent(int d, int r, int n);
        for (int k = 0; k < n; k++) if (q[d][k] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(int d, int x);
        q[d][2] = q[d][1];
        q[d][1] = q[d][0];
        q[d][0] = x;
    endtask

    // Expected outputs for the inputs currently applied.
    task automatic eval();
        #1;
        for (int d = 0; d < 2; d++) begin
            int n;
            bit m1, m2, h;
            n  = (d == 0) ? 2 : 3;
            m1 = rs1_used && (rs1 != 0) && in_recent(d, int'(rs1), n);
            m2 = rs2_used && (rs2 != 0) && in_recent(d, int'(rs2), n);
            h  = id_valid && !flush && (m1 || m2);
            if (!rst_n) begin
                dec[d] = 4; ev[d] = 6'b000000;
            end else if (mem_wait) begin
                dec[d] = 0; ev[d] = {5'b00000, h};
            end else if (flush) begin
                dec[d] = 1; ev[d] = 6'b111110;
            end else if (h) begin
                dec[d] = 2; ev[d] = 6'b000111;
            end else begin
                dec[d] = 3; ev[d] = 6'b110010;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            case (dec[d])
                1: begin push(d, -1); if (fc[d] < smax[d]) fc[d]++; end
                2: begin push(d, -1); if (sc[d] < smax[d]) sc[d]++; end
                3: push(d, (id_valid && we && rd != 0) ? int'(rd) : -1);
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic drive(bit v, bit [2:0] a, bit ua, bit [2:0] b, bit ub,
                         bit [2:0] r, bit w, bit mw, bit fl);
        id_valid = v; rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub;
        rd = r; we = w; mem_wait = mw; flush = fl;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: ;                                       // in reset from time 0
                1: begin rst_n = 1'b1; drive(1, 0, 0, 0, 0, 3, 1, 0, 0); end
                2: begin rst_n = 1'b0; model_clear(); drive(1, 3, 1, 0, 0, 0, 0, 0, 0); end
                default: rst_n = 1'b1;                     // same read of r3 after release
            endcase
            eval();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (av[d] !== ev[d]) begin bad++; $display("FAIL reset k%0d dut%0d ctl got=%b want=%b", k, d, av[d], ev[d]); end
                total++;
                if (as[d] !== 16'(sc[d]) || af[d] !== 16'(fc[d])) begin
                    bad++; $display("FAIL reset_cnt k%0d dut%0d got=%0d/%0d want=%0d/%0d", k, d, as[d], af[d], sc[d], fc[d]);
                end
            end
            if (k == 3) begin
                total++;
                if (h0 !== 1'b0 || p0 !== 1'b1) begin bad++; $display("FAIL reset_release hazard=%b pc_en=%b want 0/1", h0, p0); end
            end
            tick();
        end
    endtask

    task automatic test_raw_stall();
        int pre0, pre1;
        for (int k = 0; k < 11; k++) begin
            if (k < 3 || k > 7) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            else if (k == 3) drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
            else drive(1, 3, 1, 1, 0, 6, 0, 0, 0);
            if (k == 3) begin pre0 = sc[0]; pre1 = sc[1]; end
            eval();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (av[d] !== ev[d]) begin bad++; $display("FAIL raw k%0d dut%0d ctl got=%b want=%b", k, d, av[d], ev[d]); end
            end
            if (k >= 4 && k <= 7) begin
                total++;
                if (h0 !== (k <= 5) || h1 !== (k <= 6)) begin
                    bad++; $display("FAIL raw_haz k%0d got=%b%b want=%b%b", k, h0, h1, k <= 5, k <= 6);
                end
            end
            tick();
        end
        total++;
        if (s0 !== 16'(pre0 + 2) || s1 !== 3'(pre1 + 3)) begin
            bad++; $display("FAIL raw_cnt got=%0d/%0d want=%0d/%0d", s0, s1, pre0 + 2, pre1 + 3);
        end
    endtask

    task automatic test_zero_reg();
        for (int k = 0; k < 7; k++) begin
            case (k)
                3: drive(1, 0, 0, 0, 0, 0, 1, 0, 0);   // write r0
                4: drive(1, 0, 1, 0, 1, 5, 0, 0, 0);   // read r0, write r5 with we=0
                5: drive(1, 5, 1, 5, 1, 1, 0, 0, 0);   // read r5
                default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            eval();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (av[d] !== ev[d]) begin bad++; $display("FAIL zero k%0d dut%0d ctl got=%b want=%b", k, d, av[d], ev[d]); end
            end
            if (k == 4 || k == 5) begin
                total++;
                if (h0 !== 1'b0 || h1 !== 1'b0) begin bad++; $display("FAIL zero_haz k%0d got=%b%b want=00", k, h0, h1); end
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        int pre0, pre1;
        for (int k = 0; k < 14; k++) begin
            if (k < 3 || k > 11) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            else if (k == 3) drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
            else drive(1, 0, 0, 3, 1, 2, 0, (k <= 7), 0);
            if (k == 3) begin pre0 = sc[0]; pre1 = sc[1]; end
            eval();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (av[d] !== ev[d]) begin bad++; $display("FAIL memwait k%0d dut%0d ctl got=%b want=%b", k, d, av[d], ev[d]); end
            end
            if (k >= 4 && k <= 7) begin
                total++;
                if (av[0] !== 6'b000001 || av[1] !== 6'b000001 || s0 !== 16'(pre0)) begin
                    bad++; $display("FAIL memwait_frozen k%0d got=%b/%b cnt=%0d want=000001 cnt=%0d", k, av[0], av[1], s0, pre0);
                end
            end
            tick();
        end
        total++;
        if (s0 !== 16'(pre0 + 2) || s1 !== 3'((pre1 + 3 > 7) ? 7 : pre1 + 3)) begin
            bad++; $display("FAIL memwait_cnt got=%0d/%0d want=%0d/%0d", s0, s1, pre0 + 2, pre1 + 3);
        end
    endtask

    task automatic test_flush();
        int ps, pf;
        for (int k = 0; k < 9; k++) begin
            if (k == 3) drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
            else if (k == 4) drive(1, 3, 1, 0, 0, 4, 1, 0, 1);
            else drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (k == 3) begin ps = sc[0]; pf = fc[0]; end
            eval();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (av[d] !== ev[d]) begin bad++; $display("FAIL flush k%0d dut%0d ctl got=%b want=%b", k, d, av[d], ev[d]); end
            end
            if (k == 4) begin
                total++;
                if (av[0] !== 6'b111110 || av[1] !== 6'b111110) begin
                    bad++; $display("FAIL flush_ctl got=%b/%b want=111110", av[0], av[1]);
                end
            end
            tick();
        end
        total++;
        if (fl0 !== 16'(pf + 1) || s0 !== 16'(ps)) begin
            bad++; $display("FAIL flush_cnt got=%0d/%0d want=%0d/%0d", fl0, s0, pf + 1, ps);
        end
    endtask

    // u1's 3-bit stall counter is at 6 here; three more stalls must stick at 7.
    task automatic test_saturate();
        for (int k = 0; k < 10; k++) begin
            if (k < 3 || k > 7) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            else if (k == 3) drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
            else drive(1, 3, 1, 0, 0, 1, 0, 0, 0);
            eval();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (av[d] !== ev[d] || as[d] !== 16'(sc[d])) begin
                    bad++; $display("FAIL sat k%0d dut%0d got=%b cnt=%0d want=%b cnt=%0d", k, d, av[d], as[d], ev[d], sc[d]);
                end
            end
            tick();
        end
        total++;
        if (s1 !== 3'd7) begin bad++; $display("FAIL sat_cnt got=%0d want=7", s1); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (rst_n && $urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                model_clear();
            end else begin
                rst_n = 1'b1;
            end
            drive(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 5), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
            eval();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (av[d] !== ev[d] || as[d] !== 16'(sc[d]) || af[d] !== 16'(fc[d])) begin
                    bad++; $display("FAIL rand k%0d dut%0d got=%b %0d/%0d want=%b %0d/%0d",
                                    k, d, av[d], as[d], af[d], ev[d], sc[d], fc[d]);
                end
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    // Chain r1<-r0, r2<-r1, ...; each instruction stays in ID until u0 lets IF/ID load.
    task automatic test_back_to_back();
        int idx = 0;
        for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); eval(); tick(); end
        for (int k = 0; k < 40 && idx < 6; k++) begin
            bit adv;
            drive(1, 3'(idx), 1, 0, 0, 3'(idx + 1), 1, 0, 0);
            eval();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (av[d] !== ev[d]) begin bad++; $display("FAIL b2b k%0d dut%0d ctl got=%b want=%b", k, d, av[d], ev[d]); end
            end
            adv = f0;
            tick();
            if (adv) idx++;
        end
        total++;
        if (idx != 6) begin bad++; $display("FAIL b2b_timeout issued=%0d want=6", idx); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_raw_stall();
        test_zero_reg();
        test_mem_wait();
        test_flush();
        test_saturate();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
